// File: rtl/axi_rr_arbiter_if.sv
// axi_rr_arbiter_if: N AXI4 ports as packed per-port arrays; master drives requests, slave drives responses
// Ports: aw/w/b/ar/r channels, each [N-1:0]; *_attr = {user,region[3:0],qos[3:0],prot[2:0],cache[3:0],lock,burst[1:0],size[2:0]}
interface axi_rr_arbiter_if #(
  parameter int N  = 1,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IW = 2,
  parameter int XW = 22
);
  logic [N-1:0]               aw_valid, aw_ready;
  logic [N-1:0][AW-1:0]       aw_addr;
  logic [N-1:0][7:0]          aw_len;
  logic [N-1:0][IW-1:0]       aw_id;
  logic [N-1:0][XW-1:0]       aw_attr;
  logic [N-1:0]               w_valid, w_ready, w_last;
  logic [N-1:0][DW-1:0]       w_data;
  logic [N-1:0][DW/8-1:0]     w_strb;
  logic [N-1:0]               b_valid, b_ready;
  logic [N-1:0][1:0]          b_resp;
  logic [N-1:0][IW-1:0]       b_id;
  logic [N-1:0]               ar_valid, ar_ready;
  logic [N-1:0][AW-1:0]       ar_addr;
  logic [N-1:0][7:0]          ar_len;
  logic [N-1:0][IW-1:0]       ar_id;
  logic [N-1:0][XW-1:0]       ar_attr;
  logic [N-1:0]               r_valid, r_ready, r_last;
  logic [N-1:0][DW-1:0]       r_data;
  logic [N-1:0][1:0]          r_resp;
  logic [N-1:0][IW-1:0]       r_id;
  modport master (
    output aw_valid, aw_addr, aw_len, aw_id, aw_attr, w_valid, w_data, w_strb, w_last, b_ready,
           ar_valid, ar_addr, ar_len, ar_id, ar_attr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, b_id, ar_ready, r_valid, r_data, r_resp, r_last, r_id
  );
  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_id, aw_attr, w_valid, w_data, w_strb, w_last, b_ready,
           ar_valid, ar_addr, ar_len, ar_id, ar_attr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, b_id, ar_ready, r_valid, r_data, r_resp, r_last, r_id
  );
endinterface

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: round-robin merge of NB_MASTER AXI4 masters onto one slave, independent read/write, one outstanding each
// Ports: clk, rst_n (async active-low); m = upstream masters (NB_MASTER wide, ID AXI_ID_WIDTH);
//        s = downstream slave (single port, ID = {grant index, upstream ID})
module axi_rr_arbiter #(
  parameter int NB_MASTER      = 3,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 2
) (
  input logic              clk,
  input logic              rst_n,
  axi_rr_arbiter_if.slave  m,
  axi_rr_arbiter_if.master s
);
  localparam int GW    = $clog2(NB_MASTER);
  localparam int SID_W = AXI_ID_WIDTH + GW;
  if (NB_MASTER < 2 || NB_MASTER > 8 || AXI_ADDR_WIDTH < 1 || AXI_DATA_WIDTH % 8 != 0) begin : g_bad_cfg
    $error("axi_rr_arbiter: unsupported parameter set");
  end
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  w_state_t        wstate_q, wstate_d;
  r_state_t        rstate_q, rstate_d;
  logic [GW-1:0]   wgnt_q, wgnt_d, wptr_q, wptr_d, rgnt_q, rgnt_d, rptr_q, rptr_d;
  logic            unused_sid;
  // Scan downward so the requester closest to ptr (cyclically) is the last, winning assignment.
  function automatic logic [GW-1:0] pick(input logic [NB_MASTER-1:0] req, input logic [GW-1:0] ptr);
    logic [GW-1:0] g, k;
    g = ptr;
    for (int i = NB_MASTER - 1; i >= 0; i--) begin
      k = GW'((int'(ptr) + i) % NB_MASTER);
      if (req[k]) g = k;
    end
    return g;
  endfunction
  function automatic logic [GW-1:0] nxt(input logic [GW-1:0] g);
    return (int'(g) == NB_MASTER - 1) ? '0 : g + 1'b1;
  endfunction
  // Upper ID bits only matter for routing, which uses the held grant instead.
  assign unused_sid = ^{s.b_id[0][SID_W-1:AXI_ID_WIDTH], s.r_id[0][SID_W-1:AXI_ID_WIDTH]};
  always_comb begin
    wstate_d     = wstate_q;
    wgnt_d       = wgnt_q;
    wptr_d       = wptr_q;
    s.aw_valid   = wstate_q == W_ADDR && m.aw_valid[wgnt_q];
    s.aw_addr    = m.aw_addr[wgnt_q];
    s.aw_len     = m.aw_len[wgnt_q];
    s.aw_attr    = m.aw_attr[wgnt_q];
    s.aw_id      = {wgnt_q, m.aw_id[wgnt_q]};
    s.w_valid    = wstate_q == W_DATA && m.w_valid[wgnt_q];
    s.w_data     = m.w_data[wgnt_q];
    s.w_strb     = m.w_strb[wgnt_q];
    s.w_last     = m.w_last[wgnt_q];
    s.b_ready    = wstate_q == W_RESP && m.b_ready[wgnt_q];
    m.aw_ready   = '0;
    m.w_ready    = '0;
    m.b_valid    = '0;
    m.aw_ready[wgnt_q] = wstate_q == W_ADDR && s.aw_ready[0];
    m.w_ready[wgnt_q]  = wstate_q == W_DATA && s.w_ready[0];
    m.b_valid[wgnt_q]  = wstate_q == W_RESP && s.b_valid[0];
    m.b_resp     = {NB_MASTER{s.b_resp[0]}};
    m.b_id       = {NB_MASTER{s.b_id[0][AXI_ID_WIDTH-1:0]}};
    case (wstate_q)
      W_IDLE: if (|m.aw_valid) begin
        wgnt_d   = pick(m.aw_valid, wptr_q);
        wstate_d = W_ADDR;
      end
      W_ADDR: if (s.aw_valid[0] && s.aw_ready[0]) wstate_d = W_DATA;
      W_DATA: if (s.w_valid[0] && s.w_ready[0] && s.w_last[0]) wstate_d = W_RESP;
      W_RESP: if (s.b_valid[0] && s.b_ready[0]) begin
        wptr_d   = nxt(wgnt_q);
        wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end
  always_comb begin
    rstate_d     = rstate_q;
    rgnt_d       = rgnt_q;
    rptr_d       = rptr_q;
    s.ar_valid   = rstate_q == R_ADDR && m.ar_valid[rgnt_q];
    s.ar_addr    = m.ar_addr[rgnt_q];
    s.ar_len     = m.ar_len[rgnt_q];
    s.ar_attr    = m.ar_attr[rgnt_q];
    s.ar_id      = {rgnt_q, m.ar_id[rgnt_q]};
    s.r_ready    = rstate_q == R_DATA && m.r_ready[rgnt_q];
    m.ar_ready   = '0;
    m.r_valid    = '0;
    m.ar_ready[rgnt_q] = rstate_q == R_ADDR && s.ar_ready[0];
    m.r_valid[rgnt_q]  = rstate_q == R_DATA && s.r_valid[0];
    m.r_data     = {NB_MASTER{s.r_data[0]}};
    m.r_resp     = {NB_MASTER{s.r_resp[0]}};
    m.r_last     = {NB_MASTER{s.r_last[0]}};
    m.r_id       = {NB_MASTER{s.r_id[0][AXI_ID_WIDTH-1:0]}};
    case (rstate_q)
      R_IDLE: if (|m.ar_valid) begin
        rgnt_d   = pick(m.ar_valid, rptr_q);
        rstate_d = R_ADDR;
      end
      R_ADDR: if (s.ar_valid[0] && s.ar_ready[0]) rstate_d = R_DATA;
      R_DATA: if (s.r_valid[0] && s.r_ready[0] && s.r_last[0]) begin
        rptr_d   = nxt(rgnt_q);
        rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q <= W_IDLE;
      wgnt_q   <= '0;
      wptr_q   <= '0;
      rstate_q <= R_IDLE;
      rgnt_q   <= '0;
      rptr_q   <= '0;
    end else begin
      wstate_q <= wstate_d;
      wgnt_q   <= wgnt_d;
      wptr_q   <= wptr_d;
      rstate_q <= rstate_d;
      rgnt_q   <= rgnt_d;
      rptr_q   <= rptr_d;
    end
  end
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb_axi_rr_arbiter: directed checks of grant order, latency, routing, backpressure and async reset
module tb_axi_rr_arbiter;
  localparam int NB = 3;
  localparam int IW = 2;
  localparam int SW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  axi_rr_arbiter_if #(.N(NB), .AW(32), .DW(32), .IW(IW)) up ();
  axi_rr_arbiter_if #(.N(1), .AW(32), .DW(32), .IW(SW)) dn ();
  axi_rr_arbiter #(.NB_MASTER(NB), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .m(up), .s(dn)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  task automatic clr;
    up.aw_valid = '0; up.aw_addr = '0; up.aw_len = '0; up.aw_id = '0; up.aw_attr = '0;
    up.w_valid = '0; up.w_data = '0; up.w_strb = '0; up.w_last = '0; up.b_ready = '0;
    up.ar_valid = '0; up.ar_addr = '0; up.ar_len = '0; up.ar_id = '0; up.ar_attr = '0; up.r_ready = '0;
    dn.aw_ready = '0; dn.w_ready = '0; dn.b_valid = '0; dn.b_resp = '0; dn.b_id = '0; dn.ar_ready = '0;
    dn.r_valid = '0; dn.r_data = '0; dn.r_resp = '0; dn.r_last = '0; dn.r_id = '0;
  endtask
  task automatic all_quiet(input string tag);
    chk(tag, {dn.aw_valid, dn.w_valid, dn.ar_valid, dn.b_ready, dn.r_ready,
              up.aw_ready, up.w_ready, up.b_valid, up.ar_ready, up.r_valid}, 0);
  endtask
  // One single-beat write; the request must already be raised, the call starts in W_IDLE.
  task automatic wr1(input int g, input logic [IW-1:0] id, input logic [31:0] addr, input logic [31:0] data);
    smp; chk("aw_idle", dn.aw_valid, 0); step;
    smp; chk("aw_valid", dn.aw_valid, 1); chk("aw_id", dn.aw_id, {g[1:0], id});
    chk("aw_addr", dn.aw_addr, addr); chk("aw_ready", up.aw_ready, 3'b1 << g); step;
    up.aw_valid[g] = 0; up.w_valid[g] = 1; up.w_last[g] = 1; up.w_data[g] = data; up.w_strb[g] = 4'hF;
    smp; chk("w_valid", dn.w_valid, 1); chk("w_data", dn.w_data, data); chk("w_ready", up.w_ready, 3'b1 << g); step;
    up.w_valid[g] = 0; up.w_last[g] = 0; dn.b_valid = 1; dn.b_resp = 2'b01; dn.b_id = {g[1:0], id};
    smp; chk("b_valid", up.b_valid, 3'b1 << g); chk("b_resp", up.b_resp[g], 1); chk("b_id", up.b_id[g], id); step;
    dn.b_valid = 0;
  endtask
  // One single-beat read; the request must already be raised, the call starts in R_IDLE.
  task automatic rd1(input int g, input logic [IW-1:0] id);
    smp; chk("ar_idle", dn.ar_valid, 0); step;
    smp; chk("ar_valid", dn.ar_valid, 1); chk("ar_id", dn.ar_id, {g[1:0], id});
    chk("ar_ready", up.ar_ready, 3'b1 << g); step;
    up.ar_valid[g] = 0; dn.r_valid = 1; dn.r_last = 1; dn.r_data = 32'hA000_0000 + g; dn.r_id = {g[1:0], id};
    smp; chk("r_valid", up.r_valid, 3'b1 << g); chk("r_data", up.r_data[g], 32'hA000_0000 + g);
    chk("r_id", up.r_id[g], id); step;
    dn.r_valid = 0; dn.r_last = 0;
  endtask
  initial begin
    clr;
    smp; all_quiet("in_reset");
    step; rst_n = 1;
    smp; all_quiet("after_release");
    step;
    dn.aw_ready = 1; dn.w_ready = 1; dn.ar_ready = 1; up.b_ready = '1; up.r_ready = '1;
    up.aw_valid[1] = 1; up.aw_id[1] = 2'b10; up.aw_addr[1] = 32'h0010_0040; up.aw_len[1] = 0;
    wr1(1, 2'b10, 32'h0010_0040, 32'hDEAD_BEEF);
    // wptr is now 2: with masters 1 and 2 requesting, 2 wins, then 1
    up.aw_valid = 3'b110; up.aw_id[2] = 2'd1; up.aw_addr[2] = 32'h200; up.aw_addr[1] = 32'h100;
    wr1(2, 2'd1, 32'h200, 32'h2222_2222);
    wr1(1, 2'b10, 32'h100, 32'h1111_1111);
    up.ar_id[0] = 2'd1; up.ar_id[1] = 2'd2; up.ar_id[2] = 2'd3;
    for (int r = 0; r < 2; r++) begin
      up.ar_valid = 3'b111;
      for (int k = 0; k < 3; k++) rd1(k, 2'(k + 1));
    end
    up.ar_valid[1] = 1; up.ar_len[1] = 8'd3;
    smp; step;
    smp; chk("burst_ar_valid", dn.ar_valid, 1); chk("burst_ar_len", dn.ar_len, 3); chk("burst_ar_id", dn.ar_id, 4'h6); step;
    up.ar_valid[1] = 0;
    for (int b = 0; b < 4; b++) begin
      repeat (2) begin
        smp; chk("burst_stall", up.r_valid, 0); chk("burst_busy", dn.r_ready, 1); step;
      end
      dn.r_valid = 1; dn.r_data = 32'hB0 + b; dn.r_last = (b == 3); dn.r_id = 4'h6;
      smp; chk("burst_r_valid", up.r_valid, 3'b010); chk("burst_r_data", up.r_data[1], 32'hB0 + b);
      chk("burst_r_last", up.r_last[1], b == 3); step;
      dn.r_valid = 0; dn.r_last = 0;
    end
    smp; chk("burst_done", dn.r_ready, 0); step;
    up.aw_valid[0] = 1; up.aw_id[0] = 2'd3; up.ar_valid[2] = 1; up.ar_id[2] = 2'd1;
    smp; step;
    smp; chk("cc_aw_id", dn.aw_id, 4'h3); chk("cc_ar_id", dn.ar_id, 4'h9); step;
    up.aw_valid[0] = 0; up.ar_valid[2] = 0; up.w_valid[0] = 1; up.w_last[0] = 1; up.w_data[0] = 32'h1234_5678;
    dn.r_valid = 1; dn.r_last = 1; dn.r_id = 4'h9; dn.r_data = 32'hCAFE_F00D;
    smp; chk("cc_w_ready", up.w_ready, 3'b001); chk("cc_w_data", dn.w_data, 32'h1234_5678);
    chk("cc_r_valid", up.r_valid, 3'b100); chk("cc_r_id", up.r_id[2], 1); chk("cc_r_data", up.r_data[2], 32'hCAFE_F00D); step;
    up.w_valid[0] = 0; up.w_last[0] = 0; dn.r_valid = 0; dn.r_last = 0; dn.b_valid = 1; dn.b_id = 4'h3; dn.b_resp = 0;
    smp; chk("cc_b_valid", up.b_valid, 3'b001); chk("cc_b_id", up.b_id[0], 3); chk("cc_r_idle", dn.ar_valid, 0); step;
    dn.b_valid = 0;
    up.aw_valid[0] = 1; up.aw_id[0] = 2'd0;
    smp; step;
    smp; chk("bp_aw_id", dn.aw_id, 4'h0); step;
    up.aw_valid[0] = 0; up.w_valid[0] = 1; up.w_last[0] = 1;
    smp; step;
    up.w_valid[0] = 0; up.w_last[0] = 0; dn.b_valid = 1; dn.b_id = 4'h0; up.b_ready = 3'b110;
    up.aw_valid[1] = 1; up.aw_id[1] = 2'd2;
    repeat (5) begin
      smp; chk("bp_s_b_ready", dn.b_ready, 0); chk("bp_b_valid", up.b_valid, 3'b001);
      chk("bp_no_aw", dn.aw_valid, 0); chk("bp_no_aw_ready", up.aw_ready, 0); step;
    end
    up.b_ready = 3'b111;
    smp; chk("bp_release", dn.b_ready, 1); step;
    dn.b_valid = 0;
    smp; chk("bp_idle", dn.aw_valid, 0); step;
    smp; chk("bp_next_valid", dn.aw_valid, 1); chk("bp_next_id", dn.aw_id, 4'h6); step;
    up.aw_valid[1] = 0; up.w_valid[1] = 1; up.w_last[1] = 0; up.w_data[1] = 32'h0000_0001;
    smp; chk("rst_beat1", up.w_ready, 3'b010); step;
    up.w_data[1] = 32'h0000_0002;
    smp; chk("rst_beat2", dn.w_data, 32'h0000_0002); chk("rst_beat2_valid", dn.w_valid, 1);
    #2 rst_n = 0;
    #1 all_quiet("async_reset");
    clr;
    step; step; rst_n = 1;
    dn.aw_ready = 1; up.aw_valid = 3'b111;
    smp; chk("post_rst_idle", dn.aw_valid, 0); step;
    smp; chk("post_rst_valid", dn.aw_valid, 1); chk("post_rst_id", dn.aw_id, 4'h0);
    chk("post_rst_ready", up.aw_ready, 3'b001);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
